// File: rtl/eae_unit_pkg.sv
// Shared EAE definitions: FSM states, operation codes and iteration count.
// Used by eae_unit and its eae_div_step datapath helper.
package eae_unit_pkg;

  localparam int EAE_ITERS = 12;
  localparam int EAE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } eae_state_t;

  typedef enum logic {
    EAE_MUL = 1'b0,
    EAE_DVI = 1'b1
  } eae_op_t;

  // Value the iteration counter holds during the final iteration.
  function automatic logic [EAE_CNT_W-1:0] last_iter();
    return EAE_CNT_W'(EAE_ITERS - 1);
  endfunction

endpackage

// File: rtl/eae_unit_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, then
// subtract the divisor when it fits and shift a 1 into the quotient.
module eae_div_step #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic           fits;

  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, divisor});

  // rem < divisor on entry, so the restored remainder always fits WIDTH bits.
  assign rem_next = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/eae_unit.sv
// Extended arithmetic element: MUL ({AC,MQ} = MQ*MB + AC) and DVI ({AC,MQ} / MB).
// Define EAE_SINGLE_CYCLE_MUL_EN for a combinational multiply-add that finishes in one cycle.
module eae_unit
  import eae_unit_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] mq_in,
  input  logic [WIDTH-1:0] mb_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ac_mul,
  output logic [WIDTH-1:0] mq_mul,
  output logic [WIDTH-1:0] ac_dvi,
  output logic [WIDTH-1:0] mq_dvi,
  output logic             link_dvi
);

  eae_state_t           state, state_next;
  eae_op_t              op_sel;
  logic [EAE_CNT_W-1:0] cnt;
  logic                 last;
  logic                 dvi_ovf;

  // Work registers: {work_hi,work_lo} is the MUL partial product or the
  // DIV remainder/quotient pair; operand holds the latched MB.
  logic [WIDTH-1:0] work_hi, work_lo, operand;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  logic [WIDTH-1:0] div_rem_next, div_quo_next;

  assign op_sel  = eae_op_t'(op);
  assign last    = (cnt == last_iter());
  assign dvi_ovf = (ac_in >= mb_in);
  assign busy    = (state == ST_MUL) || (state == ST_DIV);
  assign done    = (state == ST_DONE);

  // Shift-add step: conditionally add the multiplicand, then shift the
  // (WIDTH+1)-bit sum and the multiplier right as one register.
  assign mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};

  eae_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (work_hi),
    .quo      (work_lo),
    .divisor  (operand),
    .rem_next (div_rem_next),
    .quo_next (div_quo_next)
  );

`ifdef EAE_SINGLE_CYCLE_MUL_EN
  logic [2*WIDTH-1:0] mac;
  assign mac = {{WIDTH{1'b0}}, mq_in} * {{WIDTH{1'b0}}, mb_in} + {{WIDTH{1'b0}}, ac_in};
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (op_sel == EAE_MUL) begin
`ifdef EAE_SINGLE_CYCLE_MUL_EN
            state_next = ST_DONE;
`else
            state_next = ST_MUL;
`endif
          end else begin
            state_next = dvi_ovf ? ST_DONE : ST_DIV;
          end
        end
      end
      ST_MUL:  if (last) state_next = ST_DONE;
      ST_DIV:  if (last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt     <= '0;
      work_hi <= '0;
      work_lo <= '0;
      operand <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) begin
            work_hi <= ac_in;
            work_lo <= mq_in;
            operand <= mb_in;
          end
        end
        ST_MUL: begin
          cnt     <= cnt + 1'b1;
          work_hi <= mul_hi_next;
          work_lo <= mul_lo_next;
        end
        ST_DIV: begin
          cnt     <= cnt + 1'b1;
          work_hi <= div_rem_next;
          work_lo <= div_quo_next;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Results change only on entry to DONE; the other operation's results hold.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ac_mul   <= '0;
      mq_mul   <= '0;
      ac_dvi   <= '0;
      mq_dvi   <= '0;
      link_dvi <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && op_sel == EAE_DVI && dvi_ovf) begin
            ac_dvi   <= ac_in;
            mq_dvi   <= mq_in;
            link_dvi <= 1'b1;
          end
`ifdef EAE_SINGLE_CYCLE_MUL_EN
          if (start && op_sel == EAE_MUL) begin
            ac_mul <= mac[2*WIDTH-1:WIDTH];
            mq_mul <= mac[WIDTH-1:0];
          end
`endif
        end
        ST_MUL: begin
          if (last) begin
            ac_mul <= mul_hi_next;
            mq_mul <= mul_lo_next;
          end
        end
        ST_DIV: begin
          if (last) begin
            ac_dvi   <= div_rem_next;
            mq_dvi   <= div_quo_next;
            link_dvi <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eae_unit.sv
// Self-checking bench for eae_unit: directed corner cases, mid-op start and
// reset, then random MUL/DVI checked against an arithmetic reference model.
module tb_eae_unit;

  localparam int W = 12;

  logic         clock = 1'b0;
  logic         resetN;
  logic         start;
  logic         op;
  logic [W-1:0] ac_in, mq_in, mb_in;
  logic         busy, done;
  logic [W-1:0] ac_mul, mq_mul, ac_dvi, mq_dvi;
  logic         link_dvi;

  int checks = 0;
  int errors = 0;

  // Reference model of the result registers.
  int exp_ac_mul = 0, exp_mq_mul = 0, exp_ac_dvi = 0, exp_mq_dvi = 0, exp_link = 0;

  eae_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .resetN   (resetN),
    .start    (start),
    .op       (op),
    .ac_in    (ac_in),
    .mq_in    (mq_in),
    .mb_in    (mb_in),
    .busy     (busy),
    .done     (done),
    .ac_mul   (ac_mul),
    .mq_mul   (mq_mul),
    .ac_dvi   (ac_dvi),
    .mq_dvi   (mq_dvi),
    .link_dvi (link_dvi)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, ".ac_mul"},   32'(ac_mul),   32'(exp_ac_mul));
    check({tag, ".mq_mul"},   32'(mq_mul),   32'(exp_mq_mul));
    check({tag, ".ac_dvi"},   32'(ac_dvi),   32'(exp_ac_dvi));
    check({tag, ".mq_dvi"},   32'(mq_dvi),   32'(exp_mq_dvi));
    check({tag, ".link_dvi"}, 32'(link_dvi), 32'(exp_link));
  endtask

  // Called #1 after a clock edge with the DUT idle. Issues one operation,
  // scrambles the operand inputs after acceptance, optionally pulses start
  // again in cycle T+inject, and checks busy/done every cycle plus results.
  task automatic run_op(input string tag, input bit opv, input int a, input int q,
                        input int m, input int inject);
    int lat;
    if (opv == 1'b0) begin
      int prod = q * m + a;
`ifdef EAE_SINGLE_CYCLE_MUL_EN
      lat = 1;
`else
      lat = 13;
`endif
      exp_ac_mul = prod / 4096;
      exp_mq_mul = prod % 4096;
    end else if (a >= m) begin
      lat = 1;
      exp_ac_dvi = a;
      exp_mq_dvi = q;
      exp_link   = 1;
    end else begin
      int dividend = a * 4096 + q;
      lat = 13;
      exp_mq_dvi = dividend / m;
      exp_ac_dvi = dividend % m;
      exp_link   = 0;
    end

    op    = opv;
    ac_in = W'(a);
    mq_in = W'(q);
    mb_in = W'(m);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    ac_in = W'($urandom);
    mq_in = W'($urandom);
    mb_in = W'($urandom);

    for (int k = 1; k <= lat + 2; k++) begin
      check($sformatf("%s.done@T+%0d", tag, k), 32'(done), 32'(k == lat));
      check($sformatf("%s.busy@T+%0d", tag, k), 32'(busy), 32'(k < lat));
      start = (k == inject) && (inject < lat);
      op    = 1'($urandom);
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    check_results(tag);
  endtask

  initial begin
    resetN = 1'b0;
    start  = 1'b0;
    op     = 1'b0;
    ac_in  = '1;
    mq_in  = '1;
    mb_in  = '1;
    #12;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check_results("reset");
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;

    // Directed cases (octal operands).
    run_op("mul_basic", 1'b0, 'o0000, 'o0012, 'o0003, 0);
    check("mul_basic.mq_oct", 32'(mq_mul), 32'o36);
    run_op("mul_max",   1'b0, 'o7777, 'o7777, 'o7777, 0);
    check("mul_max.ac_oct", 32'(ac_mul), 32'o7777);
    check("mul_max.mq_oct", 32'(mq_mul), 32'o0);
    run_op("dvi_basic", 1'b1, 'o0000, 'o0144, 'o0007, 0);
    check("dvi_basic.mq_oct", 32'(mq_dvi), 32'o16);
    check("dvi_basic.ac_oct", 32'(ac_dvi), 32'o2);
    run_op("dvi_ovf",   1'b1, 'o0005, 'o1234, 'o0003, 0);
    run_op("dvi_div0",  1'b1, 'o0005, 'o1234, 'o0000, 0);
    run_op("dvi_eq",    1'b1, 'o0003, 'o0001, 'o0003, 0);
    run_op("dvi_big",   1'b1, 'o7776, 'o7777, 'o7777, 0);
    run_op("mul_inject", 1'b0, 'o0000, 'o0012, 'o0003, 4);
    run_op("dvi_inject", 1'b1, 'o0001, 'o0000, 'o0002, 7);

    // Reset in cycle T+6 of a MUL: aborts with no done pulse.
    op    = 1'b0;
    ac_in = 'o0001;
    mq_in = 'o0002;
    mb_in = 'o0003;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    resetN = 1'b0;
    #1;
    exp_ac_mul = 0; exp_mq_mul = 0; exp_ac_dvi = 0; exp_mq_dvi = 0; exp_link = 0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check_results("abort");
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("abort.no_done@%0d", k), 32'(done), 32'd0);
    end
    check_results("abort.after");
    run_op("post_reset", 1'b0, 'o0000, 'o0012, 'o0003, 0);

    // Random operations; DVI biased so half the cases divide normally.
    for (int i = 0; i < 24; i++) begin
      bit opv = 1'($urandom);
      int a   = int'($urandom_range(4095, 0));
      int q   = int'($urandom_range(4095, 0));
      int m   = int'($urandom_range(4095, 0));
      if (opv && $urandom_range(1, 0) == 1) begin
        m = int'($urandom_range(4095, 1));
        a = int'($urandom_range(m - 1, 0));
      end
      run_op($sformatf("rand%0d", i), opv, a, q, m, int'($urandom_range(14, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
